lc3_mem_responder: RTL and testbench

Memory-side responder for the LC-3 control unit's memory handshake. It accepts a one-word read or write whenever the controller asserts the memory-enable control, inserts a programmable number of wait states, and then pulses ready `R` for one cycle. It backs a single-port word RAM and the four LC-3 memory-mapped device registers (KBSR, KBDR, DSR, DDR). It also raises the keyboard interrupt request that feeds the controller's `INT` input.

---
 rtl/lc3_mem_responder_pkg.sv | 22 ++
 rtl/lc3_mem_responder_if.sv | 22 ++
 rtl/lc3_mem_responder_mem_array.sv | 25 ++
 rtl/lc3_mem_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_lc3_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_mem_responder_pkg.sv
// Shared definitions for the LC-3 memory responder: device register map,
// I/O region base and the responder state encoding.
package lc3_pkg;

    localparam logic [15:0] IO_BASE   = 16'hFE00;
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        READY = 2'd2
    } resp_state_e;

    // Everything from the I/O base upward is device space, never RAM.
    function automatic logic is_io(input logic [15:0] addr);
        return addr >= IO_BASE;
    endfunction

endpackage

// File: rtl/lc3_mem_responder_if.sv
// Controller <-> memory handshake bundle: request side driven by the
// controller (MIO.EN, R.W, MAR, MDR), response side by the responder.
interface lc3_mem_responder_if;

    logic        mio_en;
    logic        r_w;
    logic [15:0] mar;
    logic [15:0] mdr_in;
    logic [15:0] mem_data;
    logic        R;

    modport master (
        output mio_en, r_w, mar, mdr_in,
        input  mem_data, R
    );

    modport slave (
        input  mio_en, r_w, mar, mdr_in,
        output mem_data, R
    );

endinterface

// File: rtl/lc3_mem_responder_mem_array.sv
// Single-port word RAM with registered read. Contents have no reset.
module lc3_mem_array #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic [MEM_AW-1:0] addr,
    input  logic              we,
    input  logic              re,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem [0:(1 << MEM_AW) - 1];

    // Write and registered read share the single address port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 controller: captures one access per
// MIO.EN request, waits WAIT_CYCLES, commits it to RAM or a device register
// and pulses R for one cycle. Also hosts the keyboard/display registers.
//
//   state | meaning
//   IDLE  | waiting for mio_en; request is captured on the accepting edge
//   BUSY  | wait states; cnt counts down to the commit edge
//   READY | access committed, R high, mem_data valid
module lc3_mem_responder
    import lc3_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int MEM_AW      = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    lc3_mem_responder_if.slave   bus,
    output logic                 INT,
    input  logic                 kb_valid,
    input  logic [7:0]           kb_data,
    output logic                 kb_ready,
    output logic                 disp_valid,
    output logic [7:0]           disp_data,
    input  logic                 disp_ready
);

    localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    resp_state_e state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept, commit;

    logic [15:0] cap_mar, cap_mdr;
    logic        cap_rw;
    logic [15:0] acc_addr, acc_wdata;
    logic        acc_rw, acc_io;

    logic        kbsr_ready, kbsr_ie, dsr_ready;
    logic [7:0]  kbdr, ddr;
    logic        kb_take, disp_take;
    logic        kbsr_wr, kbdr_rd, ddr_wr;
    logic [15:0] dev_rdata;

    logic        ram_we, ram_re;
    logic [15:0] ram_rdata;
    logic [15:0] mem_data_q;
    logic        ram_sel_q;

    // State register and wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; commit marks the edge that enters READY.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mio_en) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = READY;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_nxt = READY;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            READY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture; later bus changes are ignored until the next access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_mar <= 16'h0000;
            cap_mdr <= 16'h0000;
            cap_rw  <= 1'b0;
        end else if (accept) begin
            cap_mar <= bus.mar;
            cap_mdr <= bus.mdr_in;
            cap_rw  <= bus.r_w;
        end
    end

    // In IDLE the live bus is the access (zero-wait commit, early RAM read);
    // afterwards the captured copy is.
    always_comb begin
        acc_addr  = cap_mar;
        acc_wdata = cap_mdr;
        acc_rw    = cap_rw;
        if (state == IDLE) begin
            acc_addr  = bus.mar;
            acc_wdata = bus.mdr_in;
            acc_rw    = bus.r_w;
        end
        acc_io = is_io(acc_addr);
    end

    // RAM strobes: the read is issued one edge before READY so the
    // registered output is already valid there (on the capture edge when
    // there are no wait states).
    always_comb begin
        ram_we = commit & acc_rw & ~acc_io;
        if (WAIT_CYCLES <= 1) begin
            ram_re = accept & ~acc_rw & ~acc_io;
        end else begin
            ram_re = (state == BUSY) && (cnt == 4'd1) && !acc_rw && !acc_io;
        end
    end

    lc3_mem_array #(
        .MEM_AW (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .addr  (acc_addr[MEM_AW-1:0]),
        .we    (ram_we),
        .re    (ram_re),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // Device decode: read value and side-effect strobes for the commit edge.
    always_comb begin
        dev_rdata = 16'h0000;
        kbsr_wr   = 1'b0;
        kbdr_rd   = 1'b0;
        ddr_wr    = 1'b0;
        if (acc_io) begin
            case (acc_addr)
                KBSR_ADDR: begin
                    dev_rdata = {kbsr_ready, kbsr_ie, 14'b0};
                    kbsr_wr   = commit & acc_rw;
                end
                KBDR_ADDR: begin
                    dev_rdata = {8'b0, kbdr};
                    kbdr_rd   = commit & ~acc_rw;
                end
                DSR_ADDR:  dev_rdata = {dsr_ready, 15'b0};
                DDR_ADDR: begin
                    dev_rdata = {8'b0, ddr};
                    ddr_wr    = commit & acc_rw;
                end
                default:   dev_rdata = 16'h0000;
            endcase
        end
    end

    assign kb_take   = kb_valid & ~kbsr_ready;
    assign disp_take = disp_ready & ~dsr_ready;

    // Keyboard registers; a committing KBDR read beats a same-edge arrival.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbsr_ready <= 1'b0;
            kbsr_ie    <= 1'b0;
            kbdr       <= 8'h00;
        end else begin
            if (kb_take) begin
                kbdr <= kb_data;
            end
            if (kbdr_rd) begin
                kbsr_ready <= 1'b0;
            end else if (kb_take) begin
                kbsr_ready <= 1'b1;
            end
            if (kbsr_wr) begin
                kbsr_ie <= acc_wdata[14];
            end
        end
    end

    // Display registers; a committing DDR write beats a same-edge handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dsr_ready <= 1'b1;
            ddr       <= 8'h00;
        end else if (ddr_wr) begin
            ddr       <= acc_wdata[7:0];
            dsr_ready <= 1'b0;
        end else if (disp_take) begin
            dsr_ready <= 1'b1;
        end
    end

    // Read data for READY. With no wait states the RAM word only lands on
    // the commit edge itself, so the RAM output is forwarded directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_data_q <= 16'h0000;
            ram_sel_q  <= 1'b0;
        end else if (commit && !acc_rw) begin
            if (acc_io) begin
                mem_data_q <= dev_rdata;
                ram_sel_q  <= 1'b0;
            end else if (WAIT_CYCLES == 0) begin
                ram_sel_q  <= 1'b1;
            end else begin
                mem_data_q <= ram_rdata;
                ram_sel_q  <= 1'b0;
            end
        end
    end

    assign bus.mem_data = ram_sel_q ? ram_rdata : mem_data_q;
    assign bus.R        = (state == READY);
    assign INT          = kbsr_ready & kbsr_ie;
    assign kb_ready     = ~kbsr_ready;
    assign disp_valid   = ~dsr_ready;
    assign disp_data    = ddr;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: directed scenarios with literal expectations
// plus a randomized run against a transaction-level model of the responder.
module tb_lc3_mem_responder;

    localparam int W         = 2;
    localparam int AW        = 12;
    localparam int RAM_WORDS = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lc3_mem_responder_if bus();
    lc3_mem_responder_if bus0();

    logic       int_o, kb_ready, disp_valid, kb_valid, disp_ready;
    logic [7:0] kb_data, disp_data;
    logic       int0, kb_ready0, disp_valid0;
    logic [7:0] disp_data0;

    lc3_mem_responder #(.WAIT_CYCLES(W), .MEM_AW(AW)) dut (
        .clk(clk), .reset(reset), .bus(bus), .INT(int_o),
        .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready)
    );

    lc3_mem_responder #(.WAIT_CYCLES(0), .MEM_AW(12)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .INT(int0),
        .kb_valid(1'b0), .kb_data(8'h00), .kb_ready(kb_ready0),
        .disp_valid(disp_valid0), .disp_data(disp_data0), .disp_ready(1'b0)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          cyc = 0;
    bit          checking = 0;
    int          req_seq = 0, done_seq = 0;
    bit          p_rw;
    logic [15:0] p_addr, p_data;
    int          p_commit;
    int          r_cycle = -1;
    logic [15:0] exp_rd = 16'h0;
    bit          exp_chk = 0;
    bit          m_kbsr15, m_ie, m_dsr15;
    logic [7:0]  m_kbdr, m_ddr;
    logic [15:0] ram_m [RAM_WORDS];
    bit          ram_w [RAM_WORDS];

    always @(posedge clk or negedge reset) begin : model
        logic [15:0] rv;
        bit kb_take, disp_take, clr_kb, ddr_wr;
        int idx;
        if (!reset) begin
            m_kbsr15 = 0; m_ie = 0; m_kbdr = 8'h00;
            m_dsr15 = 1;  m_ddr = 8'h00;
            done_seq = req_seq;
            r_cycle = -1; exp_chk = 0;
        end else begin
            cyc = cyc + 1;
            kb_take   = kb_valid && !m_kbsr15;
            disp_take = disp_ready && !m_dsr15;
            clr_kb = 0; ddr_wr = 0;
            if (req_seq != done_seq && cyc == p_commit) begin
                done_seq = req_seq;
                r_cycle  = cyc;
                rv = 16'h0000;
                if (p_addr < 16'hFE00) begin
                    idx = int'(p_addr) % RAM_WORDS;
                    if (p_rw) begin
                        ram_m[idx] = p_data;
                        ram_w[idx] = 1;
                        exp_chk = 0;
                    end else begin
                        rv = ram_m[idx];
                        exp_chk = ram_w[idx];
                    end
                end else begin
                    exp_chk = !p_rw;
                    if (p_addr == 16'hFE00) begin
                        rv = {m_kbsr15, m_ie, 14'h0};
                        if (p_rw) m_ie = p_data[14];
                    end else if (p_addr == 16'hFE02) begin
                        rv = {8'h00, m_kbdr};
                        clr_kb = !p_rw;
                    end else if (p_addr == 16'hFE04) begin
                        rv = {m_dsr15, 15'h0};
                    end else if (p_addr == 16'hFE06) begin
                        rv = {8'h00, m_ddr};
                        ddr_wr = p_rw;
                    end
                end
                exp_rd = rv;
            end
            if (kb_take) begin
                m_kbdr = kb_data;
                m_kbsr15 = 1;
            end
            if (clr_kb) m_kbsr15 = 0;
            if (disp_take) m_dsr15 = 1;
            if (ddr_wr) begin
                m_ddr = p_data[7:0];
                m_dsr15 = 0;
            end
        end
    end

    // Per-cycle comparison of the W-wait DUT against the model.
    always @(negedge clk) begin
        if (reset && checking) begin
            chk("R", bus.R, (r_cycle == cyc));
            if (r_cycle == cyc && exp_chk) chk("mem_data", bus.mem_data, exp_rd);
            chk("INT", int_o, m_kbsr15 & m_ie);
            chk("kb_ready", kb_ready, !m_kbsr15);
            chk("disp_valid", disp_valid, !m_dsr15);
            chk("disp_data", disp_data, m_ddr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_side(input int mode, input int hit);
        if (mode == 1) begin
            kb_valid   = ($urandom_range(0, 3) == 0);
            kb_data    = 8'($urandom);
            disp_ready = ($urandom_range(0, 3) == 0);
        end else if (mode == 2) begin
            disp_ready = (cyc == hit);
        end
    endtask

    // Issue one access from an IDLE negedge; returns at the following IDLE negedge.
    task automatic access(input bit rw, input logic [15:0] addr, input logic [15:0] data,
                          input int mode, output logic [15:0] rd, output int lat);
        int c0, n;
        bus.mio_en = 1'b1; bus.r_w = rw; bus.mar = addr; bus.mdr_in = data;
        c0 = cyc;
        p_rw = rw; p_addr = addr; p_data = data; p_commit = c0 + 1 + W;
        req_seq++;
        drive_side(mode, c0 + W);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.mio_en = 1'b0;
                bus.r_w    = 1'($urandom);
                bus.mar    = 16'($urandom);
                bus.mdr_in = 16'($urandom);
            end
            drive_side(mode, c0 + W);
        end while (!bus.R && n < 20);
        chk("R_seen", bus.R, 1'b1);
        rd  = bus.mem_data;
        lat = cyc - c0;
        @(negedge clk);
        drive_side(mode, c0 + W);
        chk("R_width", bus.R, 1'b0);
    endtask

    initial begin
        logic [15:0] rd;
        int lat;
        reset = 1'b0;
        bus.mio_en = 0; bus.r_w = 0; bus.mar = 0; bus.mdr_in = 0;
        bus0.mio_en = 0; bus0.r_w = 0; bus0.mar = 0; bus0.mdr_in = 0;
        kb_valid = 0; kb_data = 0; disp_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_R", bus.R, 1'b0);
        chk("rst_mem_data", bus.mem_data, 16'h0000);
        chk("rst_INT", int_o, 1'b0);
        chk("rst_kb_ready", kb_ready, 1'b1);
        chk("rst_disp_valid", disp_valid, 1'b0);
        reset = 1'b1;
        checking = 1;
        @(negedge clk);

        // zero-wait instance: R in the cycle after capture, RAM aliasing
        bus0.mio_en = 1; bus0.r_w = 1; bus0.mar = 16'h0005; bus0.mdr_in = 16'hBEEF;
        chk("z_R_req", bus0.R, 1'b0);
        @(negedge clk);
        chk("z_wr_R", bus0.R, 1'b1);
        bus0.mio_en = 0;
        @(negedge clk);
        chk("z_R_width", bus0.R, 1'b0);
        bus0.mio_en = 1; bus0.r_w = 0; bus0.mar = 16'h1005;
        @(negedge clk);
        chk("z_rd_R", bus0.R, 1'b1);
        chk("z_alias", bus0.mem_data, 16'hBEEF);
        bus0.mio_en = 0;
        @(negedge clk);
        chk("z_R_drop", bus0.R, 1'b0);

        // RAM write then read
        access(1, 16'h3000, 16'h1234, 0, rd, lat);
        chk("ram_wr_lat", lat, 3);
        access(0, 16'h3000, 16'h0000, 0, rd, lat);
        chk("ram_rd", rd, 16'h1234);
        chk("ram_rd_lat", lat, 3);

        // keyboard interrupt path
        kb_data = 8'h41; kb_valid = 1;
        @(negedge clk);
        kb_valid = 0;
        chk("kb_ready_drop", kb_ready, 1'b0);
        access(1, 16'hFE00, 16'h4000, 0, rd, lat);
        chk("INT_set", int_o, 1'b1);
        access(0, 16'hFE00, 16'h0000, 0, rd, lat);
        chk("kbsr_rd", rd, 16'hC000);
        access(0, 16'hFE02, 16'h0000, 0, rd, lat);
        chk("kbdr_rd", rd, 16'h0041);
        chk("INT_clr", int_o, 1'b0);
        chk("kb_ready_back", kb_ready, 1'b1);

        // display
        access(1, 16'hFE06, 16'h0048, 0, rd, lat);
        chk("disp_valid_set", disp_valid, 1'b1);
        chk("disp_data", disp_data, 8'h48);
        access(0, 16'hFE04, 16'h0000, 0, rd, lat);
        chk("dsr_busy", rd, 16'h0000);
        disp_ready = 1;
        @(negedge clk);
        disp_ready = 0;
        chk("disp_valid_clr", disp_valid, 1'b0);
        access(0, 16'hFE04, 16'h0000, 0, rd, lat);
        chk("dsr_ready", rd, 16'h8000);

        // KBDR read collides with a pending keyboard offer
        kb_data = 8'h5A; kb_valid = 1;
        @(negedge clk);
        kb_data = 8'h77;
        access(0, 16'hFE02, 16'h0000, 0, rd, lat);
        chk("kb_coll_rd", rd, 16'h005A);
        kb_valid = 0;
        chk("kb_coll_taken", kb_ready, 1'b0);
        access(0, 16'hFE02, 16'h0000, 0, rd, lat);
        chk("kb_coll_next", rd, 16'h0077);

        // DDR write coincides with a display handshake
        access(1, 16'hFE06, 16'h0021, 0, rd, lat);
        access(1, 16'hFE06, 16'h0052, 2, rd, lat);
        chk("ddr_coll_valid", disp_valid, 1'b1);
        chk("ddr_coll_data", disp_data, 8'h52);
        access(0, 16'hFE04, 16'h0000, 0, rd, lat);
        chk("ddr_coll_dsr", rd, 16'h0000);

        // reset in the middle of a write
        access(1, 16'h0010, 16'hAAAA, 0, rd, lat);
        bus.mio_en = 1; bus.r_w = 1; bus.mar = 16'h0010; bus.mdr_in = 16'h5555;
        @(negedge clk);
        bus.mio_en = 0;
        reset = 0;
        @(negedge clk);
        chk("mid_rst_R", bus.R, 1'b0);
        chk("mid_rst_mem_data", bus.mem_data, 16'h0000);
        reset = 1;
        repeat (4) begin
            @(negedge clk);
            chk("mid_rst_noR", bus.R, 1'b0);
        end
        access(0, 16'h0010, 16'h0000, 0, rd, lat);
        chk("mid_rst_ram", rd, 16'hAAAA);
        access(0, 16'hFE00, 16'h0000, 0, rd, lat);
        chk("mid_rst_kbsr", rd, 16'h0000);
        access(0, 16'hFE02, 16'h0000, 0, rd, lat);
        chk("mid_rst_kbdr", rd, 16'h0000);
        access(0, 16'hFE04, 16'h0000, 0, rd, lat);
        chk("mid_rst_dsr", rd, 16'h8000);
        access(0, 16'hFE06, 16'h0000, 0, rd, lat);
        chk("mid_rst_ddr", rd, 16'h0000);

        // randomized traffic against the model
        for (int t = 0; t < 300; t++) begin
            int sel;
            logic [15:0] addr;
            bit rw;
            rw  = 1'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 7)      addr = 16'($urandom_range(0, 31) + 4096 * $urandom_range(0, 14));
            else if (sel < 9) addr = 16'(16'hFE00 + 2 * $urandom_range(0, 4));
            else              addr = 16'($urandom_range(16'hFE00, 16'hFFFF));
            access(rw, addr, 16'($urandom), 1, rd, lat);
            chk("rand_lat", lat, W + 1);
            repeat ($urandom_range(0, 2)) begin
                drive_side(1, 0);
                @(negedge clk);
            end
        end
        kb_valid = 0;
        disp_ready = 0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
